// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage producing ALU operands and control.
// Takes instruction + register read data over valid/ready, decodes it and
// holds the resulting bundle in an output register toward execute.
// Optional macro ALU_ISSUE_SKID_EN adds a skid register so that in_ready is a
// flop output (no combinational path from out_ready to in_ready).
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk_w_i,
    input  logic            rst_w_i_h,
    input  logic            in_valid_w_i_h,
    output logic            in_ready_w_o_h,
    input  logic [XLEN-1:0] instr_w_i,
    input  logic [XLEN-1:0] pc_w_i,
    input  logic [XLEN-1:0] rs1_data_w_i,
    input  logic [XLEN-1:0] rs2_data_w_i,
    output logic            out_valid_w_o_h,
    input  logic            out_ready_w_i_h,
    output logic [XLEN-1:0] a_data_w_o,
    output logic [XLEN-1:0] b_data_w_o,
    output logic [3:0]      alu_control_w_o,
    output logic            addi_sub_flag_w_o,
    output logic            store_force_add_flag_w_o,
    output logic            is_branch_w_o_h,
    output logic [2:0]      branch_funct3_w_o,
    output logic            illegal_w_o_h
);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctrl;
        logic            addi_sub;
        logic            force_add;
        logic            is_branch;
        logic [2:0]      br_f3;
        logic            illegal;
    } bundle_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            f7b;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] u_imm;
    bundle_t         dec_bundle;
    bundle_t         out_q;
    logic            out_valid_q;
    logic            in_fire;
    logic            out_fire;

    assign opcode = instr_w_i[6:0];
    assign f3     = instr_w_i[14:12];
    assign f7b    = instr_w_i[30];
    assign i_imm  = {{20{instr_w_i[31]}}, instr_w_i[31:20]};
    assign s_imm  = {{20{instr_w_i[31]}}, instr_w_i[31:25], instr_w_i[11:7]};
    assign u_imm  = {instr_w_i[31:12], 12'b0};

    // Decode the incoming instruction into an ALU bundle; unlisted flags stay 0.
    always_comb begin
        dec_bundle = '0;
        unique case (opcode)
            OPC_OP: begin
                dec_bundle.a        = rs1_data_w_i;
                dec_bundle.b        = rs2_data_w_i;
                dec_bundle.ctrl     = {f7b, f3};
                dec_bundle.addi_sub = f7b;
            end
            OPC_OP_IMM: begin
                dec_bundle.a    = rs1_data_w_i;
                dec_bundle.b    = i_imm;
                dec_bundle.ctrl = {(f3 == 3'b101) & f7b, f3};
            end
            OPC_LOAD: begin
                dec_bundle.a = rs1_data_w_i;
                dec_bundle.b = i_imm;
            end
            OPC_STORE: begin
                dec_bundle.a         = rs1_data_w_i;
                dec_bundle.b         = s_imm;
                dec_bundle.force_add = 1'b1;
            end
            OPC_LUI: begin
                dec_bundle.b = u_imm;
            end
            OPC_AUIPC: begin
                dec_bundle.a = pc_w_i;
                dec_bundle.b = u_imm;
            end
            OPC_BRANCH: begin
                dec_bundle.a         = rs1_data_w_i;
                dec_bundle.b         = rs2_data_w_i;
                dec_bundle.ctrl      = 4'b1000;
                dec_bundle.addi_sub  = 1'b1;
                dec_bundle.is_branch = 1'b1;
                dec_bundle.br_f3     = f3;
            end
            OPC_JAL, OPC_JALR: begin
                // Link value: pc + 4 computed by the ALU.
                dec_bundle.a = pc_w_i;
                dec_bundle.b = 32'd4;
            end
            default: begin
                // Unknown opcodes still issue so execute can raise the trap.
                dec_bundle.illegal = 1'b1;
            end
        endcase
    end

    assign in_fire  = in_valid_w_i_h & in_ready_w_o_h;
    assign out_fire = out_valid_q & out_ready_w_i_h;

`ifdef ALU_ISSUE_SKID_EN
    bundle_t skid_q;
    logic    skid_valid_q;
    logic    ready_q;

    // ready_q is the registered "skid empty" flag; reset only masks it.
    assign in_ready_w_o_h = ready_q & ~rst_w_i_h;

    // Two-entry buffer: a stalled output parks new input in skid, which
    // refills the output register on the next drain.
    always_ff @(posedge clk_w_i) begin
        if (rst_w_i_h) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else if (skid_valid_q) begin
            if (out_fire) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b1;
            end
        end else if (in_fire) begin
            if (out_valid_q && !out_ready_w_i_h) begin
                skid_q       <= dec_bundle;
                skid_valid_q <= 1'b1;
                ready_q      <= 1'b0;
            end else begin
                out_q       <= dec_bundle;
                out_valid_q <= 1'b1;
            end
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end
`else
    // Single output register: accept when empty or draining this cycle.
    assign in_ready_w_o_h = ~rst_w_i_h & (~out_valid_q | out_ready_w_i_h);

    // Load a new bundle on accept, otherwise clear valid on drain.
    always_ff @(posedge clk_w_i) begin
        if (rst_w_i_h) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            out_q       <= dec_bundle;
            out_valid_q <= 1'b1;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid_w_o_h          = out_valid_q;
    assign a_data_w_o               = out_q.a;
    assign b_data_w_o               = out_q.b;
    assign alu_control_w_o          = out_q.ctrl;
    assign addi_sub_flag_w_o        = out_q.addi_sub;
    assign store_force_add_flag_w_o = out_q.force_add;
    assign is_branch_w_o_h          = out_q.is_branch;
    assign branch_funct3_w_o        = out_q.br_f3;
    assign illegal_w_o_h            = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue: reset, decode vectors, stall, streaming
// with backpressure, and reset while bundles are buffered.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic [3:0]  ctrl;
    logic        addi_sub;
    logic        force_add;
    logic        is_branch;
    logic [2:0]  br_f3;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk_w_i                 (clk),
        .rst_w_i_h               (rst),
        .in_valid_w_i_h          (in_valid),
        .in_ready_w_o_h          (in_ready),
        .instr_w_i               (instr),
        .pc_w_i                  (pc),
        .rs1_data_w_i            (rs1),
        .rs2_data_w_i            (rs2),
        .out_valid_w_o_h         (out_valid),
        .out_ready_w_i_h         (out_ready),
        .a_data_w_o              (a_data),
        .b_data_w_o              (b_data),
        .alu_control_w_o         (ctrl),
        .addi_sub_flag_w_o       (addi_sub),
        .store_force_add_flag_w_o(force_add),
        .is_branch_w_o_h         (is_branch),
        .branch_funct3_w_o       (br_f3),
        .illegal_w_o_h           (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accept edge.
    task automatic issue_one(input logic [31:0] i_w, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
        instr = i_w; pc = p; rs1 = r1; rs2 = r2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("issue instr=%08h pc=%08h rs1=%08h rs2=%08h -> a=%08h b=%08h ctrl=%b v=%b", i_w, p, r1, r2, a_data, b_data, ctrl, out_valid);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'h40B50533; pc = 32'h0; rs1 = 32'h5; rs2 = 32'h6;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
            n_cmp++; if ({a_data, b_data, ctrl, addi_sub, force_add, is_branch, br_f3, illegal} !== 75'd0) begin
                n_err++; $display("FAIL rst_outputs: a=%h b=%h ctrl=%b need all 0", a_data, b_data, ctrl); end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b need 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_no_accept: got %b need 0", out_valid); end
        $display("reset done");
    endtask

    task automatic test_op();
        out_ready = 1'b1;
        issue_one(32'h40B50533, 32'h0, 32'd10, 32'd3);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub_valid: got %b need 1", out_valid); end
        n_cmp++; if (a_data !== 32'd10 || b_data !== 32'd3) begin n_err++; $display("FAIL sub_ops: got a=%h b=%h need a=a b=3", a_data, b_data); end
        n_cmp++; if (ctrl !== 4'b1000 || addi_sub !== 1'b1 || force_add !== 1'b0) begin
            n_err++; $display("FAIL sub_ctrl: got ctrl=%b as=%b fa=%b need 1000 1 0", ctrl, addi_sub, force_add); end
        issue_one(32'h00B57533, 32'h0, 32'hF0F0, 32'h0FF0);
        n_cmp++; if (ctrl !== 4'b0111 || addi_sub !== 1'b0 || a_data !== 32'hF0F0 || b_data !== 32'h0FF0) begin
            n_err++; $display("FAIL and_decode: got ctrl=%b as=%b a=%h b=%h need 0111 0 f0f0 0ff0", ctrl, addi_sub, a_data, b_data); end
        drain();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL op_drain: got %b need 0", out_valid); end
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        issue_one(32'hFFC12223, 32'h0, 32'h1000, 32'h55);
        n_cmp++; if (a_data !== 32'h1000 || b_data !== 32'hFFFFFFE4) begin n_err++; $display("FAIL sw_ops: got a=%h b=%h need 1000 ffffffe4", a_data, b_data); end
        n_cmp++; if (force_add !== 1'b1 || ctrl !== 4'b0000 || addi_sub !== 1'b0) begin
            n_err++; $display("FAIL sw_flags: got fa=%b ctrl=%b as=%b need 1 0000 0", force_add, ctrl, addi_sub); end
        issue_one(32'h40315293, 32'h0, 32'h80, 32'h0);
        n_cmp++; if (b_data !== 32'h00000403 || ctrl !== 4'b1101 || a_data !== 32'h80 || addi_sub !== 1'b0) begin
            n_err++; $display("FAIL srai: got a=%h b=%h ctrl=%b as=%b need 80 403 1101 0", a_data, b_data, ctrl, addi_sub); end
        issue_one(32'hFFC12283, 32'h0, 32'h2000, 32'h0);
        n_cmp++; if (a_data !== 32'h2000 || b_data !== 32'hFFFFFFFC || ctrl !== 4'b0000 || force_add !== 1'b0) begin
            n_err++; $display("FAIL lw: got a=%h b=%h ctrl=%b fa=%b need 2000 fffffffc 0000 0", a_data, b_data, ctrl, force_add); end
        issue_one(32'h123452B7, 32'h40, 32'h99, 32'h0);
        n_cmp++; if (a_data !== 32'h0 || b_data !== 32'h12345000) begin n_err++; $display("FAIL lui: got a=%h b=%h need 0 12345000", a_data, b_data); end
        issue_one(32'h00001297, 32'h100, 32'h99, 32'h0);
        n_cmp++; if (a_data !== 32'h100 || b_data !== 32'h1000) begin n_err++; $display("FAIL auipc: got a=%h b=%h need 100 1000", a_data, b_data); end
        issue_one(32'h0000006F, 32'h200, 32'h99, 32'h0);
        n_cmp++; if (a_data !== 32'h200 || b_data !== 32'd4 || ctrl !== 4'b0000) begin
            n_err++; $display("FAIL jal: got a=%h b=%h ctrl=%b need 200 4 0000", a_data, b_data, ctrl); end
        drain();
    endtask

    task automatic test_branch_illegal();
        out_ready = 1'b1;
        issue_one(32'h00B50463, 32'h0, 32'd7, 32'd7);
        n_cmp++; if (ctrl !== 4'b1000 || addi_sub !== 1'b1 || is_branch !== 1'b1 || br_f3 !== 3'b000 || a_data !== 32'd7 || b_data !== 32'd7) begin
            n_err++; $display("FAIL beq: got ctrl=%b as=%b br=%b f3=%b a=%h b=%h need 1000 1 1 000 7 7", ctrl, addi_sub, is_branch, br_f3, a_data, b_data); end
        issue_one(32'h00B51463, 32'h0, 32'd1, 32'd2);
        n_cmp++; if (is_branch !== 1'b1 || br_f3 !== 3'b001) begin n_err++; $display("FAIL bne: got br=%b f3=%b need 1 001", is_branch, br_f3); end
        issue_one(32'h0000007F, 32'h300, 32'h1234, 32'h5678);
        n_cmp++; if (out_valid !== 1'b1 || illegal !== 1'b1 || a_data !== 32'h0 || b_data !== 32'h0) begin
            n_err++; $display("FAIL illegal: got v=%b ill=%b a=%h b=%h need 1 1 0 0", out_valid, illegal, a_data, b_data); end
        n_cmp++; if (ctrl !== 4'b0000 || is_branch !== 1'b0 || br_f3 !== 3'b000 || addi_sub !== 1'b0 || force_add !== 1'b0) begin
            n_err++; $display("FAIL illegal_flags: got ctrl=%b br=%b f3=%b as=%b fa=%b need all 0", ctrl, is_branch, br_f3, addi_sub, force_add); end
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        issue_one(32'h40B50533, 32'h0, 32'd10, 32'd3);
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || a_data !== 32'd10 || b_data !== 32'd3 || ctrl !== 4'b1000) begin
                n_err++; $display("FAIL stall_hold: got v=%b a=%h b=%h ctrl=%b need 1 a 3 1000", out_valid, a_data, b_data, ctrl); end
        end
        drain();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b need 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int sent = 0;
        int rcvd = 0;
        int held = 0;
        logic exp_ready;
        logic in_f;
        logic out_f;
        for (int c = 0; c < 20 && rcvd < 4; c++) begin
            in_valid  = (sent < 4);
            instr     = 32'h00B50533;
            rs1       = 32'h11 * (sent + 1);
            rs2       = 32'h0;
            out_ready = !(c >= 1 && c <= 3);
            #1;
`ifdef ALU_ISSUE_SKID_EN
            exp_ready = (held < 2);
`else
            exp_ready = (held == 0) || out_ready;
`endif
            n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL b2b_in_ready c=%0d: got %b need %b", c, in_ready, exp_ready); end
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_dup: got a=%h with nothing outstanding", a_data);
                end else begin
                    if (a_data !== exp_q[0]) begin n_err++; $display("FAIL b2b_order: got a=%h need %h", a_data, exp_q[0]); end
                    $display("drain a=%08h", a_data);
                    void'(exp_q.pop_front());
                end
                rcvd++; held--;
            end
            if (in_f) begin
                exp_q.push_back(rs1);
                sent++; held++;
            end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (rcvd !== 4) begin n_err++; $display("FAIL b2b_count: got %0d need 4", rcvd); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_extra: got v=%b need 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue_one(32'h00B50533, 32'h0, 32'hAAAA, 32'h0);
        if (in_ready) issue_one(32'h00B50533, 32'h0, 32'hBBBB, 32'h0);
        rst = 1'b1; out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b need 0", out_valid); end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale c=%0d: got v=%b a=%h need v=0", c, out_valid, a_data); end
        end
        issue_one(32'h00B50533, 32'h0, 32'hCCCC, 32'h0);
        n_cmp++; if (out_valid !== 1'b1 || a_data !== 32'hCCCC) begin n_err++; $display("FAIL midrst_resume: got v=%b a=%h need 1 cccc", out_valid, a_data); end
        drain();
    endtask

    initial begin
        test_reset();
        test_op();
        test_imm();
        test_branch_illegal();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
